ship_placer: RTL and testbench

Ship-placement front end for the game board matrix. It converts the cursor pixel position into a packed grid index and turns the left mouse button into single-cycle `place` pulses. It sequences the host and then the guest through the setup phase, one fixed-size fleet each. Its `start`, `place` and `mouse_pos` outputs drive the board matrix directly.

---
 rtl/ship_placer.sv | 184 ++++++++++++++++++
 tb/tb_ship_placer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_placer.sv
// ship_placer: ship-placement front end for the game board matrix.
// Maps the cursor pixel position onto an 8x8 grid index and turns
// left-button presses into single-cycle place strobes. It walks the host,
// then the guest, through setup with a fixed-size fleet each.
// Optional feature macro: SHIP_DUP_CHECK_EN. When it is defined, per-player
// occupancy masks reject clicks on cells that already hold a ship.
module ship_placer #(
  parameter int BOARD_X0  = 64,
  parameter int BOARD_Y0  = 64,
  parameter int CELL_SIZE = 48,
  parameter int SHIPS     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic        setup_req,
  output logic [1:0]  start,
  output logic        place,
  output logic [5:0]  mouse_pos,
  output logic [2:0]  ships_left,
  output logic        setup_done
);

  // The phase encoding is chosen to match the start code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOST  = 2'b01,
    GUEST = 2'b10,
    DONE  = 2'b11
  } phase_e;

  localparam logic [11:0] X0      = 12'(BOARD_X0);
  localparam logic [11:0] Y0      = 12'(BOARD_Y0);
  localparam logic [2:0]  SHIPS_L = 3'(SHIPS);

  // Counts how many cell boundaries lie at or below the offset d.
  // Results 0..7 are in-grid; 8 means the cursor is past the last cell.
  function automatic logic [3:0] grid_index(input logic [11:0] d);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (32'(d) >= $unsigned(k * CELL_SIZE)) idx = idx + 4'd1;
    end
    return idx;
  endfunction

  phase_e      state_q, state_d;
  logic        left_s1_q, left_s1_d;
  logic        left_s2_q, left_s2_d;
  logic        left_s3_q, left_s3_d;
  logic        place_q, place_d;
  logic [5:0]  mouse_pos_q, mouse_pos_d;
  logic [2:0]  ships_left_q, ships_left_d;

  logic [11:0] dx, dy;
  logic [3:0]  col_raw, row_raw;
  logic        cell_valid;
  logic [5:0]  cell_idx;
  logic        rise;
  logic        placing;
  logic        dup;
  logic        accept;

`ifdef SHIP_DUP_CHECK_EN
  logic [63:0] host_mask_q, host_mask_d;
  logic [63:0] guest_mask_q, guest_mask_d;
`endif

  // Cursor to grid cell: offset from the grid origin, then comparator chain.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dx         = xpos - X0;
    dy         = ypos - Y0;
    col_raw    = grid_index(dx);
    row_raw    = grid_index(dy);
    cell_valid = (xpos >= X0) && (ypos >= Y0) && !col_raw[3] && !row_raw[3];
    cell_idx   = {row_raw[2:0], col_raw[2:0]};
  end

  // Button synchronizer, rising-edge detect and click acceptance.
  always_comb begin
    left_s1_d = left;
    left_s2_d = left_s1_q;
    left_s3_d = left_s2_q;
    rise      = left_s2_q & ~left_s3_q;
    placing   = (state_q == HOST) || (state_q == GUEST);
`ifdef SHIP_DUP_CHECK_EN
    dup = (state_q == HOST) ? host_mask_q[cell_idx] : guest_mask_q[cell_idx];
`else
    dup = 1'b0;
`endif
    accept      = rise & placing & cell_valid & ~dup;
    place_d     = accept;
    mouse_pos_d = cell_valid ? cell_idx : mouse_pos_q;
  end

  // Next phase: a fleet completes on the place cycle that consumes the last ship.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_req) state_d = HOST;
      HOST:    if (place_q && ships_left_q == 3'd1) state_d = GUEST;
      GUEST:   if (place_q && ships_left_q == 3'd1) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Remaining-ship counter: loaded on setup, decremented after each place pulse.
  always_comb begin
    ships_left_d = ships_left_q;
    if (state_q == IDLE && setup_req) begin
      ships_left_d = SHIPS_L;
    end else if (placing && place_q) begin
      if (ships_left_q == 3'd1) ships_left_d = (state_q == HOST) ? SHIPS_L : 3'd0;
      else                      ships_left_d = ships_left_q - 3'd1;
    end
  end

`ifdef SHIP_DUP_CHECK_EN
  // Occupancy masks: cleared on setup, marked on the edge that accepts a click.
  always_comb begin
    host_mask_d  = host_mask_q;
    guest_mask_d = guest_mask_q;
    if (state_q == IDLE && setup_req) begin
      host_mask_d  = '0;
      guest_mask_d = '0;
    end else if (accept) begin
      if (state_q == HOST) host_mask_d[cell_idx]  = 1'b1;
      else                 guest_mask_d[cell_idx] = 1'b1;
    end
  end

  // Mask storage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the masks are plain flops, so they take the async reset like any state.
    if (!rst_n) begin
      host_mask_q  <= '0;
      guest_mask_q <= '0;
    end else begin
      host_mask_q  <= host_mask_d;
      guest_mask_q <= guest_mask_d;
    end
  end
`endif

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: synchronizer, strobe, cursor cell, ship counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_s1_q    <= 1'b0;
      left_s2_q    <= 1'b0;
      left_s3_q    <= 1'b0;
      place_q      <= 1'b0;
      mouse_pos_q  <= 6'd0;
      ships_left_q <= 3'd0;
    end else begin
      left_s1_q    <= left_s1_d;
      left_s2_q    <= left_s2_d;
      left_s3_q    <= left_s3_d;
      place_q      <= place_d;
      mouse_pos_q  <= mouse_pos_d;
      ships_left_q <= ships_left_d;
    end
  end

  // Outputs decoded from the phase register and the datapath flops.
  always_comb begin
    start      = state_q;
    setup_done = (state_q == DONE);
    place      = place_q;
    mouse_pos  = mouse_pos_q;
    ships_left = ships_left_q;
  end

endmodule

// File: tb/tb_ship_placer.sv
// Testbench for ship_placer: grid-mapping vector table, hand-written timing,
// hold and reset sequences, and random clicks checked against a
// phase/fleet model that uses plain division for the grid.
module tb_ship_placer;

  localparam int X0 = 64;
  localparam int Y0 = 64;
  localparam int CS = 48;
  localparam int NS = 4;
`ifdef SHIP_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos, ypos;
  logic        left, setup_req;
  logic [1:0]  start;
  logic        place;
  logic [5:0]  mouse_pos;
  logic [2:0]  ships_left;
  logic        setup_done;

  always #5 clk = ~clk;

  ship_placer #(.BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_SIZE(CS), .SHIPS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .left(left),
    .setup_req(setup_req), .start(start), .place(place),
    .mouse_pos(mouse_pos), .ships_left(ships_left), .setup_done(setup_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase;            // 0 idle, 1 host, 2 guest, 3 done
  int m_ships;
  bit m_set [2][64];

  function automatic bit cell_of(input int x, input int y, output int idx);
    int c, r;
    idx = 0;
    if (x < X0 || y < Y0) return 1'b0;
    c = (x - X0) / CS;
    r = (y - Y0) / CS;
    if (c > 7 || r > 7) return 1'b0;
    idx = r * 8 + c;
    return 1'b1;
  endfunction

  task automatic model_clear_sets();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 64; i++) m_set[p][i] = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ships = 0;
    model_clear_sets();
  endtask

  task automatic pulse_setup();
    @(negedge clk) setup_req = 1'b1;
    @(negedge clk) setup_req = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1;
      m_ships = NS;
      model_clear_sets();
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " ships_left"}, 32'(ships_left), m_ships);
    check({tag, " start"}, 32'(start), m_phase);
    check({tag, " setup_done"}, 32'(setup_done), (m_phase == 3) ? 1 : 0);
  endtask

  // One complete press/release with the model deciding acceptance.
  task automatic do_click(input int x, input int y, input int hold, input string tag);
    int idx, pulses;
    bit valid, acc;
    logic [5:0] pos_at;
    logic [1:0] st_at;
    valid  = cell_of(x, y, idx);
    acc    = (m_phase == 1 || m_phase == 2) && valid && !(DUP && m_set[m_phase-1][idx]);
    pulses = 0;
    pos_at = '0;
    st_at  = '0;
    @(negedge clk);
    xpos = x[11:0];
    ypos = y[11:0];
    left = 1'b1;
    for (int i = 0; i < hold + 5; i++) begin
      @(negedge clk);
      if (i == hold - 1) left = 1'b0;
      if (place) begin
        pulses++;
        pos_at = mouse_pos;
        st_at  = start;
      end
    end
    check({tag, " pulses"}, pulses, acc ? 1 : 0);
    if (acc) begin
      check({tag, " mouse_pos"}, 32'(pos_at), idx);
      check({tag, " start_at_place"}, 32'(st_at), m_phase);
      m_set[m_phase-1][idx] = 1'b1;
      m_ships--;
      if (m_ships == 0) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_ships = NS;
        end else begin
          m_phase = 3;
        end
      end
    end
    check_state(tag);
  endtask

  // ---------------- grid-mapping vectors ----------------
  typedef struct {
    int         x;
    int         y;
    logic [5:0] exp_pos;
  } map_vec_t;

  map_vec_t map_tab [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int iter;
    map_tab[0] = '{170, 213, 6'h1A};
    map_tab[1] = '{64, 64, 6'h00};
    map_tab[2] = '{447, 447, 6'h3F};
    map_tab[3] = '{63, 200, 6'h3F};   // left of grid: hold
    map_tab[4] = '{112, 111, 6'h01};
    map_tab[5] = '{448, 64, 6'h01};   // column 8: hold
    map_tab[6] = '{300, 400, 6'h3C};
    map_tab[7] = '{4095, 4095, 6'h3C};
    map_tab[8] = '{111, 159, 6'h08};

    rst_n = 1'b0; left = 1'b0; setup_req = 1'b0; xpos = '0; ypos = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset place", 32'(place), 0);
    check("reset mouse_pos", 32'(mouse_pos), 0);
    check_state("reset");
    rst_n = 1'b1;

    // Grid mapping with the button idle.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      xpos = map_tab[i].x[11:0];
      ypos = map_tab[i].y[11:0];
      @(negedge clk);
      check($sformatf("map[%0d] mouse_pos", i), 32'(mouse_pos), 32'(map_tab[i].exp_pos));
      check($sformatf("map[%0d] place", i), 32'(place), 0);
    end

    // Clicks in IDLE are ignored.
    do_click(170, 213, 4, "idle_click");

    pulse_setup();
    check_state("setup");

    // Exact latency of the first click.
    @(negedge clk);
    xpos = 12'd170; ypos = 12'd213; left = 1'b1;
    @(negedge clk) check("lat k place", 32'(place), 0);
    @(negedge clk) check("lat k+1 place", 32'(place), 0);
    @(negedge clk);
    check("lat k+2 place", 32'(place), 1);
    check("lat k+2 mouse_pos", 32'(mouse_pos), 32'h1A);
    check("lat k+2 start", 32'(start), 1);
    check("lat k+2 ships_left", 32'(ships_left), 4);
    @(negedge clk);
    check("lat k+3 place", 32'(place), 0);
    check("lat k+3 ships_left", 32'(ships_left), 3);
    left = 1'b0;
    repeat (4) @(negedge clk);
    m_set[0][26] = 1'b1;
    m_ships = 3;

    // Off-grid presses.
    do_click(40, 100, 4, "left_of_grid");
    do_click(500, 100, 4, "right_of_grid");

    // setup_req outside IDLE is ignored.
    pulse_setup();
    check_state("setup_ignored");

    // Long hold yields a single strobe.
    do_click(200, 200, 100, "hold100");

    // Repeat of cell 0x1A: rejected with duplicate check, consumes a ship without.
    do_click(170, 213, 6, "repeat_cell");

    // Random clicks until the model reaches DONE.
    iter = 0;
    while (m_phase != 3 && iter < 300) begin
      do_click(int'($urandom_range(30, 480)), int'($urandom_range(30, 480)),
               int'($urandom_range(4, 8)), "rnd");
      iter++;
    end
    check("reach_done start", 32'(start), 3);

    // Clicks after setup is complete.
    do_click(100, 100, 4, "done_click0");
    do_click(300, 250, 4, "done_click1");

    // Reset mid-GUEST with the button held and a strobe in flight.
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    pulse_setup();
    do_click(70, 70, 4, "host_a");
    do_click(120, 70, 4, "host_b");
    do_click(170, 70, 4, "host_c");
    do_click(220, 70, 4, "host_d");
    check("in_guest start", 32'(start), 2);
    @(negedge clk);
    xpos = 12'd300; ypos = 12'd300; left = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset place", 32'(place), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async place", 32'(place), 0);
    check("async mouse_pos", 32'(mouse_pos), 0);
    check_state("async_reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset place", 32'(place), 0);
    check("post_reset start", 32'(start), 0);
    left = 1'b0;
    repeat (4) @(negedge clk);
    pulse_setup();
    check_state("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
